// File: rtl/plic_pkg.sv
// Shared register offsets and sizing helpers for the platform-level interrupt controller.
package plic_pkg;

  localparam logic [11:0] PRIO_BASE = 12'h000;
  localparam logic [11:0] PEND_OFS  = 12'h100;
  localparam logic [11:0] EN_OFS    = 12'h104;
  localparam logic [11:0] THR_OFS   = 12'h108;
  localparam logic [11:0] CLAIM_OFS = 12'h10C;
  localparam logic [11:0] MODE_OFS  = 12'h110;

  // Width needed to hold source IDs 0..num_src, where 0 means "no interrupt".
  function automatic int id_w(input int num_src);
    return $clog2(num_src + 1);
  endfunction

endpackage

// File: rtl/plic_gateway.sv
// Per-source gateway: input synchroniser, edge detect, pending / in-service tracking
// and a one-deep latch for edges that arrive while the source is being serviced.
module plic_gateway #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic irq_i,
  input  logic mode_i,
  input  logic claim_i,
  input  logic complete_i,
  output logic pending_o
);

  logic sync, rise;
  logic prev_q;
  logic pend_q, pend_d;
  logic svc_q, svc_d;
  logic lat_q, lat_d;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign sync = irq_i;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= irq_i;
        for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
    end
    assign sync = sync_q[SYNC_STAGES-1];
  end

  assign rise = sync & ~prev_q;

  always_comb begin
    pend_d = pend_q;
    svc_d  = svc_q;
    lat_d  = lat_q;
    if (mode_i) begin
      if (rise) begin
        if (svc_q || claim_i) lat_d = 1'b1;
        else                  pend_d = 1'b1;
      end
    end else if (sync && !svc_q) begin
      pend_d = 1'b1;
    end
    // Claim wins over a gateway set landing on the same edge.
    if (claim_i) begin
      pend_d = 1'b0;
      svc_d  = 1'b1;
    end
    if (complete_i && svc_q) begin
      svc_d = 1'b0;
      if (mode_i) begin
        pend_d = pend_d | lat_q | rise;
        lat_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_q <= 1'b0;
      pend_q <= 1'b0;
      svc_q  <= 1'b0;
      lat_q  <= 1'b0;
    end else begin
      prev_q <= sync;
      pend_q <= pend_d;
      svc_q  <= svc_d;
      lat_q  <= lat_d;
    end
  end

  assign pending_o = pend_q;

endmodule

// File: rtl/plic_core.sv
// Platform-level interrupt controller: register file, priority/threshold arbiter,
// claim/complete handshake and the registered machine external interrupt.
module plic_core
  import plic_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int PRIO_W      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               req_valid,
  input  logic               req_we,
  input  logic [11:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               rsp_valid,
  output logic [31:0]        rsp_rdata,
  output logic               ext_irq
);

  localparam int IDW = id_w(NUM_SRC);

  logic [PRIO_W-1:0]  prio_q [1:NUM_SRC];
  logic [PRIO_W-1:0]  prio_d [1:NUM_SRC];
  logic [NUM_SRC:1]   en_q, en_d, mode_q, mode_d;
  logic [PRIO_W-1:0]  thr_q, thr_d;
  logic               rsp_valid_q, ext_irq_q;
  logic [31:0]        rsp_rdata_q, rdata_d;

  logic [NUM_SRC:1]   pend, claim_v, cmpl_v;
  logic [IDW-1:0]     max_id;
  logic [PRIO_W-1:0]  max_prio;
  logic               rd, wr, claim_rd, cmpl_wr, prio_hit;
  logic [5:0]         prio_idx;

  assign rd       = req_valid && !req_we;
  assign wr       = req_valid && req_we;
  assign claim_rd = rd && (req_addr == CLAIM_OFS);
  assign cmpl_wr  = wr && (req_addr == CLAIM_OFS);
  assign prio_idx = req_addr[7:2];
  assign prio_hit = (req_addr[11:8] == PRIO_BASE[11:8]) && (req_addr[1:0] == 2'b00) &&
                    (prio_idx != 6'd0) && (prio_idx <= 6'(NUM_SRC));

  // Strict '>' while scanning upward keeps the lowest ID on priority ties.
  always_comb begin
    max_id   = '0;
    max_prio = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      if (pend[i] && en_q[i] && (prio_q[i] > thr_q) && (prio_q[i] > max_prio)) begin
        max_id   = IDW'(i);
        max_prio = prio_q[i];
      end
    end
  end

  always_comb begin
    claim_v = '0;
    cmpl_v  = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      claim_v[i] = claim_rd && (max_id == IDW'(i));
      cmpl_v[i]  = cmpl_wr && (req_wdata == 32'(i));
    end
  end

  for (genvar g = 1; g <= NUM_SRC; g++) begin : g_src
    plic_gateway #(.SYNC_STAGES(SYNC_STAGES)) u_gw (
      .clk        (clk),
      .rstn       (rstn),
      .irq_i      (irq_src[g-1]),
      .mode_i     (mode_q[g]),
      .claim_i    (claim_v[g]),
      .complete_i (cmpl_v[g]),
      .pending_o  (pend[g])
    );
  end

  always_comb begin
    prio_d  = prio_q;
    en_d    = en_q;
    thr_d   = thr_q;
    mode_d  = mode_q;
    rdata_d = '0;
    if (wr) begin
      for (int i = 1; i <= NUM_SRC; i++)
        if (prio_hit && (prio_idx == 6'(i))) prio_d[i] = req_wdata[PRIO_W-1:0];
      case (req_addr)
        EN_OFS:   en_d   = req_wdata[NUM_SRC:1];
        THR_OFS:  thr_d  = req_wdata[PRIO_W-1:0];
        MODE_OFS: mode_d = req_wdata[NUM_SRC:1];
        default:  ;
      endcase
    end
    if (rd) begin
      for (int i = 1; i <= NUM_SRC; i++)
        if (prio_hit && (prio_idx == 6'(i))) rdata_d = 32'(prio_q[i]);
      case (req_addr)
        PEND_OFS:  rdata_d = 32'({pend, 1'b0});
        EN_OFS:    rdata_d = 32'({en_q, 1'b0});
        THR_OFS:   rdata_d = 32'(thr_q);
        CLAIM_OFS: rdata_d = 32'(max_id);
        MODE_OFS:  rdata_d = 32'({mode_q, 1'b0});
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 1; i <= NUM_SRC; i++) prio_q[i] <= '0;
      en_q        <= '0;
      thr_q       <= '0;
      mode_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      ext_irq_q   <= 1'b0;
    end else begin
      prio_q      <= prio_d;
      en_q        <= en_d;
      thr_q       <= thr_d;
      mode_q      <= mode_d;
      rsp_valid_q <= rd;
      rsp_rdata_q <= rdata_d;
      ext_irq_q   <= (max_id != '0);
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign ext_irq   = ext_irq_q;

endmodule
